// File: rtl/sdr_params_pkg.sv
// Shared SDRAM write-path parameters and the write-buffer FSM state encoding.
package sdr_params_pkg;

  localparam int DSIZE     = 32;
  localparam int BURST_LEN = 4;
  localparam int DEPTH     = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sdr_wfifo_mem.sv
// Write-buffer storage: DEPTH entries of {masks, data} with wrapping head/tail pointers.
module sdr_wfifo_mem #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: the array has no reset branch so it maps onto plain RAM; only the pointers reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sdr_wr_buffer.sv
// Host write buffer feeding the SDRAM data path: collects beats, drains them as fixed-length bursts.
module sdr_wr_buffer #(
  parameter int DSIZE     = sdr_params_pkg::DSIZE,
  parameter int DEPTH     = sdr_params_pkg::DEPTH,
  parameter int BURST_LEN = sdr_params_pkg::BURST_LEN,
  localparam int MW       = DSIZE / 8,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [DSIZE-1:0] HOST_WDATA,
  input  logic [MW-1:0]    HOST_WDM,
  input  logic             HOST_WVALID,
  output logic             HOST_WREADY,
  output logic             BURST_AVAIL,
  input  logic             WR_REQ,
  output logic [DSIZE-1:0] WDATA_OUT,
  output logic [MW-1:0]    WDM_OUT,
  output logic             WR_ACTIVE,
  output logic [LW-1:0]    LEVEL,
  output logic             UNDERRUN
);

  import sdr_params_pkg::wr_state_e;
  import sdr_params_pkg::ST_IDLE;
  import sdr_params_pkg::ST_BURST;

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  wr_state_e            state;
  wr_state_e            state_nxt;
  logic [CW-1:0]        beat_cnt;
  logic                 push;
  logic                 pop;
  logic                 last_beat;
  logic [MW+DSIZE-1:0]  rd_data;

  assign HOST_WREADY = RESET_N && (LEVEL < LW'(DEPTH));
  assign BURST_AVAIL = (LEVEL >= LW'(BURST_LEN));
  assign push        = HOST_WVALID && HOST_WREADY;
  assign pop         = (state == ST_BURST);
  assign last_beat   = (beat_cnt == CW'(BURST_LEN - 1));

  sdr_wfifo_mem #(
    .WIDTH (MW + DSIZE),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .wr_en   (push),
    .wr_data ({HOST_WDM, HOST_WDATA}),
    .rd_en   (pop),
    .rd_data (rd_data)
  );

  // NOTE: state_nxt is assigned before the case so every path drives it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (WR_REQ && BURST_AVAIL) state_nxt = ST_BURST;
      ST_BURST: if (last_beat)             state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      LEVEL     <= '0;
      WDATA_OUT <= '0;
      WDM_OUT   <= '1;
      WR_ACTIVE <= 1'b0;
      UNDERRUN  <= 1'b0;
    end else begin
      state    <= state_nxt;
      LEVEL    <= LEVEL + LW'(push) - LW'(pop);
      beat_cnt <= (pop && !last_beat) ? beat_cnt + 1'b1 : '0;
      // Idle output is data 0 with every byte masked, so the data path writes nothing.
      if (pop) begin
        WDATA_OUT <= rd_data[DSIZE-1:0];
        WDM_OUT   <= rd_data[MW+DSIZE-1:DSIZE];
        WR_ACTIVE <= 1'b1;
      end else begin
        WDATA_OUT <= '0;
        WDM_OUT   <= '1;
        WR_ACTIVE <= 1'b0;
      end
      if (state == ST_IDLE && WR_REQ && !BURST_AVAIL) UNDERRUN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdr_wr_buffer.sv
// Directed bench for sdr_wr_buffer: bursts, full/underrun boundaries, pointer wrap, masks, reset mid-burst.
module tb_sdr_wr_buffer;

  localparam int DSIZE     = 32;
  localparam int DEPTH     = 8;
  localparam int BURST_LEN = 4;

  typedef struct packed {
    logic [3:0]  dm;
    logic [31:0] data;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] HOST_WDATA;
  logic [3:0]  HOST_WDM;
  logic        HOST_WVALID;
  logic        HOST_WREADY;
  logic        BURST_AVAIL;
  logic        WR_REQ;
  logic [31:0] WDATA_OUT;
  logic [3:0]  WDM_OUT;
  logic        WR_ACTIVE;
  logic [3:0]  LEVEL;
  logic        UNDERRUN;

  int    vectors    = 0;
  int    miscompares = 0;
  beat_t exp_q[$];

  sdr_wr_buffer #(
    .DSIZE     (DSIZE),
    .DEPTH     (DEPTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .HOST_WDATA  (HOST_WDATA),
    .HOST_WDM    (HOST_WDM),
    .HOST_WVALID (HOST_WVALID),
    .HOST_WREADY (HOST_WREADY),
    .BURST_AVAIL (BURST_AVAIL),
    .WR_REQ      (WR_REQ),
    .WDATA_OUT   (WDATA_OUT),
    .WDM_OUT     (WDM_OUT),
    .WR_ACTIVE   (WR_ACTIVE),
    .LEVEL       (LEVEL),
    .UNDERRUN    (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m);
    HOST_WDATA  = d;
    HOST_WDM    = m;
    HOST_WVALID = 1'b1;
    check("push_ready", HOST_WREADY, 1);
    step();
    HOST_WVALID = 1'b0;
    exp_q.push_back({m, d});
  endtask

  // WR_REQ at edge N, beats expected after N+1..N+BURST_LEN, idle output after that.
  task automatic burst(input bit mid_req);
    beat_t b;
    WR_REQ = 1'b1;
    step();
    WR_REQ = 1'b0;
    check("burst_edge_n_active", WR_ACTIVE, 0);
    check("burst_edge_n_dm", WDM_OUT, 4'hF);
    for (int i = 0; i < BURST_LEN; i++) begin
      WR_REQ = mid_req && (i == 1);
      step();
      b = exp_q.pop_front();
      check("burst_data", WDATA_OUT, b.data);
      check("burst_dm", WDM_OUT, b.dm);
      check("burst_active", WR_ACTIVE, 1);
    end
    WR_REQ = 1'b0;
    step();
    check("burst_end_active", WR_ACTIVE, 0);
    check("burst_end_dm", WDM_OUT, 4'hF);
    check("burst_end_data", WDATA_OUT, 0);
  endtask

  initial begin
    beat_t b;
    RESET_N     = 1'b0;
    HOST_WDATA  = '0;
    HOST_WDM    = '0;
    HOST_WVALID = 1'b0;
    WR_REQ      = 1'b0;

    // Reset state
    step();
    step();
    check("rst_ready", HOST_WREADY, 0);
    check("rst_level", LEVEL, 0);
    check("rst_dm", WDM_OUT, 4'hF);
    check("rst_data", WDATA_OUT, 0);
    check("rst_active", WR_ACTIVE, 0);
    check("rst_underrun", UNDERRUN, 0);
    RESET_N = 1'b1;
    step();
    check("post_rst_ready", HOST_WREADY, 1);
    check("post_rst_avail", BURST_AVAIL, 0);

    // Basic burst of four beats
    push(32'h1111_1111, 4'h0);
    push(32'h2222_2222, 4'h0);
    push(32'h3333_3333, 4'h0);
    check("avail_at_3", BURST_AVAIL, 0);
    push(32'h4444_4444, 4'h0);
    check("level_4", LEVEL, 4);
    check("avail_at_4", BURST_AVAIL, 1);
    burst(1'b0);
    check("level_after_burst1", LEVEL, 0);
    check("no_underrun_yet", UNDERRUN, 0);

    // Underrun: request with only three beats stored
    push(32'h3000_0000, 4'h0);
    push(32'h3000_0001, 4'h0);
    push(32'h3000_0002, 4'h0);
    WR_REQ = 1'b1;
    step();
    WR_REQ = 1'b0;
    check("underrun_set", UNDERRUN, 1);
    check("underrun_level", LEVEL, 3);
    step();
    check("underrun_no_burst", WR_ACTIVE, 0);
    check("underrun_dm", WDM_OUT, 4'hF);

    // Fill to DEPTH with valid held high
    HOST_WVALID = 1'b1;
    HOST_WDM    = 4'h0;
    for (int i = 0; i < 5; i++) begin
      HOST_WDATA = 32'hF000_0000 + i;
      step();
      exp_q.push_back({4'h0, 32'hF000_0000 + i});
    end
    check("full_level", LEVEL, 8);
    check("full_ready", HOST_WREADY, 0);
    HOST_WDATA = 32'hF000_0005;
    step();
    step();
    check("ninth_held_level", LEVEL, 8);

    // Burst from full with pushes during pops and a stray mid-burst request
    WR_REQ = 1'b1;
    step();
    WR_REQ = 1'b0;
    check("full_burst_edge_n_level", LEVEL, 8);
    for (int i = 0; i < BURST_LEN; i++) begin
      WR_REQ = (i == 1);
      step();
      WR_REQ = 1'b0;
      b = exp_q.pop_front();
      check("full_burst_data", WDATA_OUT, b.data);
      check("full_burst_active", WR_ACTIVE, 1);
      check("push_pop_level", LEVEL, 7);
      if (i < 3) begin
        HOST_WDATA = 32'hF000_0005 + i;
        exp_q.push_back({4'h0, 32'hF000_0005 + i});
      end else begin
        HOST_WVALID = 1'b0;
      end
    end
    step();
    check("full_burst_end_active", WR_ACTIVE, 0);
    check("full_burst_end_dm", WDM_OUT, 4'hF);
    step();
    check("mid_req_ignored", WR_ACTIVE, 0);
    check("level_7_kept", LEVEL, 7);

    // Draining across the pointer wrap with mixed masks
    burst(1'b1);
    check("underrun_sticky_1", UNDERRUN, 1);
    check("level_3", LEVEL, 3);
    push(32'hA5A5_0000, 4'h5);
    push(32'hA5A5_0001, 4'hA);
    burst(1'b0);
    check("level_1", LEVEL, 1);
    push(32'hA5A5_0002, 4'h0);
    push(32'hA5A5_0003, 4'hA);
    push(32'hA5A5_0004, 4'h5);
    burst(1'b0);
    check("level_0_wrap", LEVEL, 0);
    check("underrun_sticky_2", UNDERRUN, 1);

    // Reset on the second beat of a burst
    push(32'hBEEF_0000, 4'h0);
    push(32'hBEEF_0001, 4'h0);
    push(32'hBEEF_0002, 4'h0);
    push(32'hBEEF_0003, 4'h0);
    WR_REQ = 1'b1;
    step();
    WR_REQ = 1'b0;
    step();
    check("pre_rst_beat0", WDATA_OUT, 32'hBEEF_0000);
    RESET_N = 1'b0;
    step();
    exp_q.delete();
    check("mid_rst_active", WR_ACTIVE, 0);
    check("mid_rst_level", LEVEL, 0);
    check("mid_rst_dm", WDM_OUT, 4'hF);
    check("mid_rst_underrun", UNDERRUN, 0);
    RESET_N = 1'b1;
    step();
    check("after_rst_active", WR_ACTIVE, 0);
    push(32'h6000_0000, 4'h3);
    push(32'h6000_0001, 4'hC);
    push(32'h6000_0002, 4'h0);
    push(32'h6000_0003, 4'hF);
    burst(1'b0);
    check("final_level", LEVEL, 0);
    check("final_underrun", UNDERRUN, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
